// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA channel scheduler: FSM state encoding, default
// widths and the command record handed to the engine.
package dma_sched_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_AW  = 32;
    localparam int DEF_LW  = 16;
    localparam int DEF_TMO = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } dma_state_e;

    typedef struct packed {
        logic [DEF_AW-1:0] src;
        logic [DEF_AW-1:0] dst;
        logic [DEF_LW-1:0] len;
    } dma_cmd_t;

endpackage

// File: rtl/dma_rr_arb.sv
// Round-robin picker: the first requester at or after ptr (wrapping) wins.
// Purely combinational, one-hot grant, all-zero when nothing requests.
module dma_rr_arb #(
    parameter int NCH = 4,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] gnt
);

    logic found;

    // Outer loop walks priority offsets from ptr; the inner loop maps an
    // offset back onto its physical channel, handling the wrap.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!found && req[c] &&
                    ((int'(ptr) + k == c) || (int'(ptr) + k == c + NCH))) begin
                    gnt[c] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dma_ch_sched.sv
// Multi-channel DMA command scheduler: round-robin picks a channel, issues its
// command to the engine and reports completion. DMA_SCHED_WATCHDOG_EN adds a BUSY timeout.
module dma_ch_sched
    import dma_sched_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int AW         = DEF_AW,
    parameter int LW         = DEF_LW,
    parameter int TMO_CYCLES = DEF_TMO
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [NCH-1:0]  ch_req_i,
    input  logic [NCH*AW-1:0] ch_src_i,
    input  logic [NCH*AW-1:0] ch_dst_i,
    input  logic [NCH*LW-1:0] ch_len_i,
    output logic [NCH-1:0]  ch_grant_o,
    output logic [NCH-1:0]  ch_done_o,
    output logic [NCH-1:0]  ch_err_o,
    output logic            cmd_valid_o,
    input  logic            cmd_ready_i,
    output logic [AW-1:0]   cmd_src_o,
    output logic [AW-1:0]   cmd_dst_o,
    output logic [LW-1:0]   cmd_len_o,
    input  logic            dma_done_i,
    input  logic            dma_err_i,
    output logic            abort_o,
    output logic            busy_o,
    output logic            irq_o,
    input  logic            irq_clr_i,
    output logic [1:0]      dbg_state_o
);

    localparam int PW = $clog2(NCH);

    logic [1:0]     rst_sync;
    logic           rst_n;
    dma_state_e     state_q, state_d;
    logic [PW-1:0]  ptr_q, idx_q, pick_idx;
    logic [NCH-1:0] arb_gnt, chan_oh;
    logic [AW-1:0]  src_q, dst_q, pick_src, pick_dst;
    logic [LW-1:0]  len_q, pick_len;
    logic           err_q, irq_q, wd_hit;

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
        return (i == PW'(NCH-1)) ? '0 : i + PW'(1);
    endfunction

    // Reset asserts asynchronously, releases only after two clock edges.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    dma_rr_arb #(.NCH(NCH), .PW(PW)) u_arb (
        .req (ch_req_i),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        pick_idx = '0;
        pick_src = '0;
        pick_dst = '0;
        pick_len = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_gnt[i]) begin
                pick_idx = PW'(i);
                pick_src = ch_src_i[i*AW +: AW];
                pick_dst = ch_dst_i[i*AW +: AW];
                pick_len = ch_len_i[i*LW +: LW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|ch_req_i) state_d = (pick_len == '0) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (cmd_ready_i) state_d = ST_BUSY;
            ST_BUSY:  if (dma_done_i || dma_err_i || wd_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // The latched command is the only source of the payload, so channel
    // inputs may change freely once a request has been accepted.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            idx_q <= '0;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (|ch_req_i) begin
                    idx_q <= pick_idx;
                    src_q <= pick_src;
                    dst_q <= pick_dst;
                    len_q <= pick_len;
                    err_q <= 1'b0;
                    if (pick_len == '0) ptr_q <= ptr_after(pick_idx);
                end
                ST_ISSUE: if (cmd_ready_i) ptr_q <= ptr_after(idx_q);
                ST_BUSY:  err_q <= dma_err_i | (wd_hit & ~dma_done_i);
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (irq_q & ~irq_clr_i) | ((state_q == ST_RESP) & err_q);
    end

`ifdef DMA_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] wd_cnt_q;
    logic          tmo_q;

    assign wd_hit = (wd_cnt_q == CW'(TMO_CYCLES - 1));

    // tmo_q marks a RESP that was reached by timeout rather than by the engine.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE && cmd_ready_i) wd_cnt_q <= '0;
            else if (state_q == ST_BUSY)            wd_cnt_q <= wd_cnt_q + CW'(1);
            if (state_q != ST_RESP)
                tmo_q <= (state_q == ST_BUSY) & wd_hit & ~dma_done_i & ~dma_err_i;
        end
    end

    assign abort_o = (state_q == ST_RESP) & tmo_q;
`else
    assign wd_hit  = 1'b0;
    assign abort_o = 1'b0;
`endif

    // Engine handshake: cmd_valid_o rises in ISSUE with a stable payload and
    // holds until the cycle cmd_ready_i is high; that cycle is the transfer.
    assign chan_oh     = NCH'(1) << idx_q;
    assign cmd_valid_o = (state_q == ST_ISSUE);
    assign cmd_src_o   = src_q;
    assign cmd_dst_o   = dst_q;
    assign cmd_len_o   = len_q;
    assign ch_grant_o  = (state_q == ST_ISSUE && cmd_ready_i) ? chan_oh : '0;
    assign ch_done_o   = (state_q == ST_RESP && !err_q) ? chan_oh : '0;
    assign ch_err_o    = (state_q == ST_RESP &&  err_q) ? chan_oh : '0;
    assign busy_o      = (state_q != ST_IDLE);
    assign irq_o       = irq_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dma_ch_sched.sv
// Self-checking bench for dma_ch_sched: directed scenarios, command and
// response scoreboards. Honours DMA_SCHED_WATCHDOG_EN like the design.
module tb_dma_ch_sched;
    import dma_sched_pkg::*;

    localparam int NCH   = 4;
    localparam int AW    = 32;
    localparam int LW    = 16;
    localparam int TMO   = 16;
    localparam int CMD_W = $bits(dma_cmd_t);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    ch_req_i = '0;
    logic [NCH*AW-1:0] ch_src_i = '0;
    logic [NCH*AW-1:0] ch_dst_i = '0;
    logic [NCH*LW-1:0] ch_len_i = '0;
    logic [NCH-1:0]    ch_grant_o, ch_done_o, ch_err_o;
    logic              cmd_valid_o;
    logic              cmd_ready_i = 1'b1;
    logic [AW-1:0]     cmd_src_o, cmd_dst_o;
    logic [LW-1:0]     cmd_len_o;
    logic              dma_done_i = 1'b0;
    logic              dma_err_i = 1'b0;
    logic              abort_o, busy_o, irq_o;
    logic              irq_clr_i = 1'b0;
    logic [1:0]        dbg_state_o;

    logic [CMD_W-1:0]  exp_q[$];
    logic [NCH-1:0]    gnt_q[$];
    logic [NCH:0]      resp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    dma_ch_sched #(.NCH(NCH), .AW(AW), .LW(LW), .TMO_CYCLES(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .ch_req_i    (ch_req_i),
        .ch_src_i    (ch_src_i),
        .ch_dst_i    (ch_dst_i),
        .ch_len_i    (ch_len_i),
        .ch_grant_o  (ch_grant_o),
        .ch_done_o   (ch_done_o),
        .ch_err_o    (ch_err_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_src_o   (cmd_src_o),
        .cmd_dst_o   (cmd_dst_o),
        .cmd_len_o   (cmd_len_o),
        .dma_done_i  (dma_done_i),
        .dma_err_i   (dma_err_i),
        .abort_o     (abort_o),
        .busy_o      (busy_o),
        .irq_o       (irq_o),
        .irq_clr_i   (irq_clr_i),
        .dbg_state_o (dbg_state_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic set_ch(input int ch, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [LW-1:0] len);
        ch_src_i[ch*AW +: AW] = src;
        ch_dst_i[ch*AW +: AW] = dst;
        ch_len_i[ch*LW +: LW] = len;
    endtask

    task automatic push_cmd(input int ch);
        dma_cmd_t c;
        c.src = ch_src_i[ch*AW +: AW];
        c.dst = ch_dst_i[ch*AW +: AW];
        c.len = ch_len_i[ch*LW +: LW];
        exp_q.push_back(c);
        gnt_q.push_back(NCH'(1) << ch);
    endtask

    task automatic wait_hs(input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cmd_valid_o && cmd_ready_i) && n < max_cyc);
        if (!(cmd_valid_o && cmd_ready_i)) check("hs_timeout", cmd_valid_o & cmd_ready_i, 1);
    endtask

    task automatic pulse_eng(input logic d, input logic e, input int ch, input int dly);
        logic [NCH-1:0] oh;
        oh = NCH'(1) << ch;
        repeat (dly) @(posedge clk);
        #1;
        dma_done_i = d;
        dma_err_i  = e;
        resp_q.push_back({e, oh});
        @(posedge clk);
        #1;
        dma_done_i = 1'b0;
        dma_err_i  = 1'b0;
    endtask

    task automatic clear_irq();
        @(posedge clk); #1 irq_clr_i = 1'b1;
        @(posedge clk); #1 irq_clr_i = 1'b0;
        @(negedge clk);
        check("irq_cleared", irq_o, 0);
    endtask

    // scoreboard
    always @(negedge clk) begin : mon
        dma_cmd_t c;
        logic [NCH-1:0] g;
        logic [NCH:0] r;
        if (cmd_valid_o && cmd_ready_i) begin
            if (exp_q.size() == 0) begin
                check("cmd_q_nonempty", exp_q.size(), 1);
            end else begin
                c = dma_cmd_t'(exp_q.pop_front());
                g = gnt_q.pop_front();
                check("cmd_src", cmd_src_o, c.src);
                check("cmd_dst", cmd_dst_o, c.dst);
                check("cmd_len", cmd_len_o, c.len);
                check("grant", ch_grant_o, g);
            end
        end else if (ch_grant_o != '0) begin
            check("grant_stray", ch_grant_o, 0);
        end
        if ((ch_done_o | ch_err_o) != '0) begin
            if (resp_q.size() == 0) begin
                check("resp_q_nonempty", resp_q.size(), 1);
            end else begin
                r = resp_q.pop_front();
                check("resp_done", ch_done_o, r[NCH] ? NCH'(0) : r[NCH-1:0]);
                check("resp_err",  ch_err_o,  r[NCH] ? r[NCH-1:0] : NCH'(0));
            end
        end
    end

    initial begin
        int n;
        logic [AW-1:0] a;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_valid", cmd_valid_o, 0);
        check("rst_src", cmd_src_o, 0);
        check("rst_len", cmd_len_o, 0);
        check("rst_pulses", {ch_grant_o, ch_done_o, ch_err_o}, 0);
        check("rst_abort", abort_o, 0);
        check("rst_irq", irq_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // single request on ch1, len 64, done 10 cycles later
        set_ch(1, $urandom(), $urandom(), 16'd64);
        ch_req_i[1] = 1'b1;
        push_cmd(1);
        @(negedge clk);
        check("t1_idle_valid", cmd_valid_o, 0);
        @(negedge clk);
        check("t1_valid_lat", cmd_valid_o, 1);
        check("t1_len", cmd_len_o, 64);
        check("t1_grant", ch_grant_o, 4'b0010);
        ch_req_i = '0;
        pulse_eng(1'b1, 1'b0, 1, 10);
        @(negedge clk);
        check("t1_done", ch_done_o, 4'b0010);
        @(negedge clk);
        check("t1_idle", busy_o, 0);

        // engine pulses outside BUSY
        @(posedge clk); #1 dma_done_i = 1'b1; dma_err_i = 1'b1;
        @(posedge clk); #1 dma_done_i = 1'b0; dma_err_i = 1'b0;
        @(negedge clk);
        check("stray_busy", busy_o, 0);
        check("stray_resp", ch_done_o | ch_err_o, 0);
        check("stray_irq", irq_o, 0);

        // reset during BUSY on ch2
        @(posedge clk); #1;
        set_ch(2, $urandom(), $urandom(), LW'($urandom_range(1, 65535)));
        ch_req_i[2] = 1'b1;
        push_cmd(2);
        wait_hs(10);
        ch_req_i = '0;
        repeat (3) @(negedge clk);
        check("rb_busy_before", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_busy", busy_o, 0);
        check("rb_state", dbg_state_o, 0);
        check("rb_valid", cmd_valid_o, 0);
        check("rb_pulses", {ch_grant_o, ch_done_o, ch_err_o, abort_o}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // fairness: all channels requesting, expect 0,1,2,3,0
        for (int c = 0; c < NCH; c++)
            set_ch(c, $urandom(), $urandom(), LW'($urandom_range(1, 65535)));
        ch_req_i = '1;
        for (int k = 0; k < 5; k++) begin
            push_cmd(k % NCH);
            wait_hs(20);
            if (k == 4) ch_req_i = '0;
            pulse_eng(1'b1, 1'b0, k % NCH, $urandom_range(1, 4));
        end
        repeat (2) @(negedge clk);

        // zero-length on ch2: no command, immediate done, pointer moves to 3
        @(posedge clk); #1;
        set_ch(2, $urandom(), $urandom(), '0);
        ch_req_i[2] = 1'b1;
        resp_q.push_back({1'b0, 4'b0100});
        @(negedge clk);
        @(negedge clk);
        check("zl_done", ch_done_o, 4'b0100);
        check("zl_no_cmd", cmd_valid_o, 0);
        ch_req_i = '0;
        repeat (2) @(negedge clk);

        @(posedge clk); #1;
        set_ch(1, $urandom(), $urandom(), LW'($urandom_range(1, 65535)));
        set_ch(3, $urandom(), $urandom(), LW'($urandom_range(1, 65535)));
        ch_req_i = 4'b1010;
        push_cmd(3);
        wait_hs(10);
        ch_req_i = '0;
        pulse_eng(1'b1, 1'b0, 3, 2);
        repeat (2) @(negedge clk);

        // backpressure on ch3: ready low 5 cycles, source changes mid-wait
        @(posedge clk); #1;
        cmd_ready_i = 1'b0;
        a = $urandom();
        set_ch(3, a, $urandom(), LW'($urandom_range(1, 65535)));
        ch_req_i[3] = 1'b1;
        push_cmd(3);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("bp_valid", cmd_valid_o, 1);
            check("bp_nogrant", ch_grant_o, 0);
            check("bp_src", cmd_src_o, a);
            if (k == 3) ch_src_i[3*AW +: AW] = ~a;
        end
        @(posedge clk); #1 cmd_ready_i = 1'b1;
        @(negedge clk);
        check("bp_grant", ch_grant_o, 4'b1000);
        ch_req_i = '0;
        pulse_eng(1'b1, 1'b0, 3, 2);
        repeat (2) @(negedge clk);

        // done and err together on ch0: error wins, irq sticky
        @(posedge clk); #1;
        set_ch(0, $urandom(), $urandom(), LW'($urandom_range(1, 65535)));
        ch_req_i[0] = 1'b1;
        push_cmd(0);
        wait_hs(10);
        ch_req_i = '0;
        pulse_eng(1'b1, 1'b1, 0, 3);
        @(negedge clk);
        check("de_err", ch_err_o, 4'b0001);
        check("de_nodone", ch_done_o, 0);
        @(negedge clk);
        check("de_irq", irq_o, 1);
        repeat (3) @(negedge clk);
        check("de_irq_sticky", irq_o, 1);

        // irq_clr in the same cycle as a new error keeps irq set
        @(posedge clk); #1;
        set_ch(2, $urandom(), $urandom(), LW'($urandom_range(1, 65535)));
        ch_req_i[2] = 1'b1;
        push_cmd(2);
        wait_hs(10);
        ch_req_i = '0;
        pulse_eng(1'b0, 1'b1, 2, 2);
        irq_clr_i = 1'b1;
        @(posedge clk); #1 irq_clr_i = 1'b0;
        @(negedge clk);
        check("clr_vs_err_irq", irq_o, 1);
        clear_irq();

        // watchdog on ch1
        @(posedge clk); #1;
        set_ch(1, $urandom(), $urandom(), LW'($urandom_range(1, 65535)));
        ch_req_i[1] = 1'b1;
        push_cmd(1);
        wait_hs(10);
        ch_req_i = '0;
`ifdef DMA_SCHED_WATCHDOG_EN
        resp_q.push_back({1'b1, 4'b0010});
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (abort_o) break;
            @(posedge clk);
            n++;
        end
        check("wd_cycles", n, TMO);
        check("wd_abort", abort_o, 1);
        check("wd_err", ch_err_o, 4'b0010);
        @(negedge clk);
        check("wd_abort_1cyc", abort_o, 0);
        check("wd_irq", irq_o, 1);
        clear_irq();
`else
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_o && !abort_o) n++;
        end
        check("nowd_busy_cycles", n, 40);
        pulse_eng(1'b1, 1'b0, 1, 1);
        @(negedge clk);
        check("nowd_done", ch_done_o, 4'b0010);
`endif

        // final report
        repeat (3) @(negedge clk);
        check("cmd_q_left", exp_q.size(), 0);
        check("resp_q_left", resp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_ch_sched.md
DMA_CH_SCHED -- requirements
Module: dma_ch_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter LW, default 16, transfer-length width in bytes.
REQ-004 SHALL have parameter TMO_CYCLES, default 4096, BUSY-state watchdog limit.
REQ-005 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port ch_req_i  in  NCH  per-channel transfer request, held until granted.
REQ-008 SHALL have ports ch_src_i / ch_dst_i  in  NCH*AW  packed per-channel source/destination addresses.
REQ-009 SHALL have port ch_len_i  in  NCH*LW  packed per-channel byte length.
REQ-010 SHALL have port ch_grant_o  out  NCH  one-hot, 1-cycle pulse: channel command accepted by the engine.
REQ-011 SHALL have ports ch_done_o / ch_err_o  out  NCH  one-hot 1-cycle completion/error pulses.
REQ-012 SHALL have ports cmd_valid_o out 1, cmd_ready_i in 1, cmd_src_o out AW, cmd_dst_o out AW, cmd_len_o out LW  command to axi_dma.
REQ-013 SHALL have ports dma_done_i / dma_err_i  in  1  engine completion/error pulses.
REQ-014 SHALL have port abort_o  out  1  1-cycle engine abort pulse.
REQ-015 SHALL have ports busy_o out 1 (state != IDLE), irq_o out 1 (sticky error), irq_clr_i in 1 (clears irq_o).

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
REQ-017 IDLE: any ch_req_i set -> round-robin pick, starting at the channel after the last granted one; latch index, src, dst, len; go to ISSUE next cycle.
REQ-018 Zero-length request: no command issued; IDLE -> RESP; ch_done_o pulses for that channel.
REQ-019 ISSUE: cmd_valid_o=1, payload stable from latch until cmd_ready_i=1; on handshake ch_grant_o pulses, go to BUSY.
REQ-020 BUSY: dma_done_i -> RESP(ok); dma_err_i -> RESP(err); both in the same cycle -> err wins.
REQ-021 RESP: exactly one cycle; pulse ch_done_o or ch_err_o for the latched channel; error sets irq_o; return to IDLE.
REQ-022 Latency: request in IDLE -> cmd_valid_o 1 cycle later; dma_done_i -> ch_done_o 1 cycle later.
REQ-023 dma_done_i/dma_err_i outside BUSY SHALL be ignored.
REQ-024 Changes to ch_*_i after latch SHALL NOT alter the command in flight.
REQ-025 irq_clr_i and a new error in the same cycle -> irq_o stays 1.
REQ-026 RR pointer SHALL advance only on grant or zero-length completion, wrapping NCH-1 -> 0.

Reset
REQ-027 Reset SHALL force IDLE; RR pointer so channel 0 has highest priority; all outputs 0; in-flight command dropped without pulses.
REQ-028 Deassertion SHALL be synchronized to wb_clk_i internally before use.

Configuration
REQ-029 With DMA_SCHED_WATCHDOG_EN defined: counter clears on BUSY entry, increments in BUSY; reaching TMO_CYCLES -> abort_o pulse, ch_err_o pulse, irq_o set, RESP -> IDLE.
REQ-030 Without DMA_SCHED_WATCHDOG_EN: no counter; abort_o tied 0; BUSY waits indefinitely.

Structure
REQ-031 Shared package dma_sched_pkg SHALL hold the FSM state enum, default widths, and the command record type (src, dst, len).
REQ-032 Round-robin picker SHALL be the sub-module dma_rr_arb (NCH-wide, req vector + pointer -> one-hot grant).

Verification
REQ-033 Single request: ch1 req, len=64, cmd_ready_i immediate, dma_done_i 10 cycles later -> cmd_len_o=64, ch_grant_o=0010, ch_done_o=0010 one cycle after done.
REQ-034 Fairness: ch0..ch3 requesting continuously -> grant order 0,1,2,3,0 with no channel repeated.
REQ-035 Backpressure: cmd_ready_i low 5 cycles, ch_src_i changed mid-wait -> cmd_src_o unchanged, grant on cycle 6.
REQ-036 Done+err same cycle -> ch_err_o pulse, no ch_done_o, irq_o=1 until irq_clr_i.
REQ-037 Watchdog (macro on, TMO_CYCLES=16): no dma_done_i -> abort_o and ch_err_o pulse exactly 16 cycles after BUSY entry; macro off -> stays busy.
REQ-038 Reset asserted in BUSY -> outputs 0 immediately, IDLE, ch0 granted first afterwards.
